rvfpm_bitops_pipe: RTL and testbench

RVFPM_BITOPS_PIPE -- requirements
Module: rvfpm_bitops_pipe

---
 rtl/rvfpm_pkg.sv | 74 +++++++
 rtl/rvfpm_fclass.sv | 38 +++
 rtl/rvfpm_bitops_pipe.sv | 151 +++++++++++++++
 tb/tb_rvfpm_bitops_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfpm_pkg.sv
// rtl/rvfpm_pkg.sv - shared decode constants, op enum, FCLASS bit map and pipeline entry type
package rvfpm_pkg;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    localparam logic [6:0] F7_FSGNJ   = 7'b0010000;
    localparam logic [6:0] F7_FMINMAX = 7'b0010100;
    localparam logic [6:0] F7_FMV_X_W = 7'b1110000;  // shared with FCLASS
    localparam logic [6:0] F7_FMV_W_X = 7'b1111000;

    localparam logic [2:0] F3_0 = 3'b000;
    localparam logic [2:0] F3_1 = 3'b001;
    localparam logic [2:0] F3_2 = 3'b010;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // FCLASS one-hot bit positions; the non-NaN positions are in ascending
    // numeric order, which the min/max comparator relies on.
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    typedef enum logic [2:0] {
        OP_FSGNJ,
        OP_FSGNJN,
        OP_FSGNJX,
        OP_FMIN,
        OP_FMAX,
        OP_FMV_X_W,
        OP_FCLASS,
        OP_FMV_W_X
    } fp_op_e;

    typedef struct packed {
        logic        valid;
        fp_op_e      op;
        logic [4:0]  rd;
        logic [31:0] a;   // rs1 value, or the integer operand for FMV.W.X
        logic [31:0] b;   // rs2 value
    } pipe_entry_t;

    typedef struct packed {
        logic   valid;
        fp_op_e op;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.valid = 1'b0;
        d.op    = OP_FSGNJ;
        if (ins[6:0] == OPC_OP_FP) begin
            case ({ins[31:25], ins[14:12]})
                {F7_FSGNJ,   F3_0}: begin d.valid = 1'b1; d.op = OP_FSGNJ;   end
                {F7_FSGNJ,   F3_1}: begin d.valid = 1'b1; d.op = OP_FSGNJN;  end
                {F7_FSGNJ,   F3_2}: begin d.valid = 1'b1; d.op = OP_FSGNJX;  end
                {F7_FMINMAX, F3_0}: begin d.valid = 1'b1; d.op = OP_FMIN;    end
                {F7_FMINMAX, F3_1}: begin d.valid = 1'b1; d.op = OP_FMAX;    end
                {F7_FMV_X_W, F3_0}: begin d.valid = 1'b1; d.op = OP_FMV_X_W; end
                {F7_FMV_X_W, F3_1}: begin d.valid = 1'b1; d.op = OP_FCLASS;  end
                {F7_FMV_W_X, F3_0}: begin d.valid = 1'b1; d.op = OP_FMV_W_X; end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rvfpm_fclass.sv
// rtl/rvfpm_fclass.sv - combinational single-precision classifier
//   value : IEEE 754 binary32 operand
//   cls   : one-hot class (-inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN at bits 0..9)
module rvfpm_fclass
    import rvfpm_pkg::*;
(
    input  logic [31:0] value,
    output logic [9:0]  cls
);

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] man;

    assign sign = value[31];
    assign expo = value[30:23];
    assign man  = value[22:0];

    always_comb begin
        cls = '0;
        if (expo == 8'hFF) begin
            if (man == '0)
                cls[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            else if (man[22])
                cls[CLS_QNAN] = 1'b1;
            else
                cls[CLS_SNAN] = 1'b1;
        end else if (expo == 8'h00) begin
            if (man == '0)
                cls[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            else
                cls[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
        end else begin
            cls[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/rvfpm_bitops_pipe.sv
// rtl/rvfpm_bitops_pipe.sv - pipelined RV32F sign-inject/min/max/move/classify unit with register file
//   ck, rst         : clock, synchronous active-high reset
//   enable          : advance the pipeline and accept instruction; 0 freezes everything
//   instruction     : RV32F word, data_fromXReg: integer operand for FMV.W.X
//   data_toXReg     : integer result of FMV.X.W / FCLASS, toXReg_valid marks its update
//   illegal_instr   : last accepted word was not a supported op
//   fflags          : sticky NV,DZ,OF,UF,NX
//   registerFile    : architectural FP registers
module rvfpm_bitops_pipe
    import rvfpm_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [31:0]                instruction,
    input  logic [31:0]                data_fromXReg,
    output logic [31:0]                data_toXReg,
    output logic                       toXReg_valid,
    output logic                       illegal_instr,
    output logic [4:0]                 fflags,
    output logic [NUM_REGS-1:0][31:0]  registerFile
);

    localparam int LAST = PIPELINE_STAGES;

    // stages[0] is loaded at the accepting edge, stages[LAST] retires on the next.
    pipe_entry_t stages [PIPELINE_STAGES+1];
    pipe_entry_t ret;
    pipe_entry_t new_entry;
    dec_t        dec;

    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] op_a, op_b;

    logic [9:0]  cls_a, cls_b;
    logic        a_nan, b_nan, a_snan, b_snan;
    logic        mag_lt, a_lt_b;
    logic [31:0] minmax;

    logic        fp_we, fp_commit, x_we, nv;
    logic [4:0]  wb_rd;
    logic [31:0] fp_data, x_data;

    assign ret     = stages[LAST];
    assign wb_rd   = ret.rd;
    assign dec     = decode(instruction);
    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];

    rvfpm_fclass u_fclass_a (.value(ret.a), .cls(cls_a));
    rvfpm_fclass u_fclass_b (.value(ret.b), .cls(cls_b));

    assign a_nan  = cls_a[CLS_SNAN] | cls_a[CLS_QNAN];
    assign b_nan  = cls_b[CLS_SNAN] | cls_b[CLS_QNAN];
    assign a_snan = cls_a[CLS_SNAN];
    assign b_snan = cls_b[CLS_SNAN];

    // Non-NaN classes are one-hot in ascending order, so comparing the class
    // vectors orders different classes (including -0 < +0); within a class
    // the sign is shared and magnitude decides.
    always_comb begin
        mag_lt = ret.a[31] ? (ret.a[30:0] > ret.b[30:0]) : (ret.a[30:0] < ret.b[30:0]);
        a_lt_b = (cls_a < cls_b) || ((cls_a == cls_b) && mag_lt);
        if (a_nan && b_nan)
            minmax = CANON_NAN;
        else if (a_nan)
            minmax = ret.b;
        else if (b_nan)
            minmax = ret.a;
        else if (ret.op == OP_FMAX)
            minmax = a_lt_b ? ret.b : ret.a;
        else
            minmax = a_lt_b ? ret.a : ret.b;
    end

    always_comb begin
        fp_we   = 1'b0;
        x_we    = 1'b0;
        nv      = 1'b0;
        fp_data = '0;
        x_data  = '0;
        if (ret.valid) begin
            case (ret.op)
                OP_FSGNJ:   begin fp_we = 1'b1; fp_data = {ret.b[31], ret.a[30:0]}; end
                OP_FSGNJN:  begin fp_we = 1'b1; fp_data = {~ret.b[31], ret.a[30:0]}; end
                OP_FSGNJX:  begin fp_we = 1'b1; fp_data = {ret.a[31] ^ ret.b[31], ret.a[30:0]}; end
                OP_FMIN,
                OP_FMAX:    begin fp_we = 1'b1; fp_data = minmax; nv = a_snan | b_snan; end
                OP_FMV_X_W: begin x_we = 1'b1; x_data = ret.a; end
                OP_FCLASS:  begin x_we = 1'b1; x_data = {22'b0, cls_a}; end
                OP_FMV_W_X: begin fp_we = 1'b1; fp_data = ret.a; end
                default: ;
            endcase
        end
    end

    // A write to an index beyond the register file is dropped, and must not
    // leak into the operand bypass either.
    always_comb begin
        fp_commit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (fp_we && wb_rd == 5'(i)) fp_commit = 1'b1;
    end

    // Operand read sees the write retiring on this same edge; in-flight
    // stages are deliberately not forwarded.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs1_idx == 5'(i)) op_a = registerFile[i];
            if (rs2_idx == 5'(i)) op_b = registerFile[i];
        end
        if (fp_commit && rs1_idx == wb_rd) op_a = fp_data;
        if (fp_commit && rs2_idx == wb_rd) op_b = fp_data;
    end

    always_comb begin
        new_entry.valid = dec.valid;
        new_entry.op    = dec.op;
        new_entry.rd    = instruction[11:7];
        new_entry.a     = (dec.op == OP_FMV_W_X) ? data_fromXReg : op_a;
        new_entry.b     = op_b;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i <= LAST; i++) stages[i] <= '0;
            registerFile  <= '0;
            data_toXReg   <= '0;
            toXReg_valid  <= 1'b0;
            illegal_instr <= 1'b0;
            fflags        <= '0;
        end else if (enable) begin
            stages[0] <= new_entry;
            for (int i = 1; i <= LAST; i++) stages[i] <= stages[i-1];
            for (int i = 0; i < NUM_REGS; i++)
                if (fp_we && wb_rd == 5'(i)) registerFile[i] <= fp_data;
            toXReg_valid <= x_we;
            if (x_we) data_toXReg <= x_data;
            fflags        <= fflags | {nv, 4'b0000};
            illegal_instr <= ~dec.valid;
        end else begin
            toXReg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvfpm_bitops_pipe.sv
// tb/tb_rvfpm_bitops_pipe.sv - scoreboard bench for rvfpm_bitops_pipe
module tb_rvfpm_bitops_pipe;

    localparam int NR = 32;
    localparam int P  = 4;

    localparam int K_FSGNJ  = 0;
    localparam int K_FSGNJN = 1;
    localparam int K_FSGNJX = 2;
    localparam int K_FMIN   = 3;
    localparam int K_FMAX   = 4;
    localparam int K_FMVXW  = 5;
    localparam int K_FCLASS = 6;
    localparam int K_FMVWX  = 7;
    localparam int K_FADD   = 8;
    localparam int K_NOP    = 9;

    logic                  ck = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [31:0]           instruction;
    logic [31:0]           data_fromXReg;
    logic [31:0]           data_toXReg;
    logic                  toXReg_valid;
    logic                  illegal_instr;
    logic [4:0]            fflags;
    logic [NR-1:0][31:0]   registerFile;

    always #5 ck = ~ck;

    rvfpm_bitops_pipe #(.NUM_REGS(NR), .PIPELINE_STAGES(P)) dut (
        .ck            (ck),
        .rst           (rst),
        .enable        (enable),
        .instruction   (instruction),
        .data_fromXReg (data_fromXReg),
        .data_toXReg   (data_toXReg),
        .toXReg_valid  (toXReg_valid),
        .illegal_instr (illegal_instr),
        .fflags        (fflags),
        .registerFile  (registerFile)
    );

    typedef struct {
        int          due;
        bit          is_x;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          nv;
    } sb_t;

    sb_t sb[$];

    int total = 0;
    int bad   = 0;
    int acc   = 0;

    logic [NR-1:0][31:0] mrf;
    logic [31:0]         mdata;
    logic [4:0]          mflags;
    logic                mill;

    function automatic logic [31:0] enc(input int k, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = 7'b0000000;
        f3 = 3'b000;
        case (k)
            K_FSGNJ:  begin f7 = 7'b0010000; f3 = 3'b000; end
            K_FSGNJN: begin f7 = 7'b0010000; f3 = 3'b001; end
            K_FSGNJX: begin f7 = 7'b0010000; f3 = 3'b010; end
            K_FMIN:   begin f7 = 7'b0010100; f3 = 3'b000; end
            K_FMAX:   begin f7 = 7'b0010100; f3 = 3'b001; end
            K_FMVXW:  begin f7 = 7'b1110000; f3 = 3'b000; end
            K_FCLASS: begin f7 = 7'b1110000; f3 = 3'b001; end
            K_FMVWX:  begin f7 = 7'b1111000; f3 = 3'b000; end
            K_NOP:    return 32'h0000_0013;
            default:  begin f7 = 7'b0000000; f3 = 3'b000; end
        endcase
        return {f7, rs2, rs1, f3, rd, 7'b1010011};
    endfunction

    function automatic bit m_isnan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic bit m_issnan(input logic [31:0] v);
        return m_isnan(v) && !v[22];
    endfunction

    function automatic logic [9:0] m_class(input logic [31:0] v);
        if (m_isnan(v))             return v[22] ? 10'h200 : 10'h100;
        if (v[30:0] == 31'h7F800000) return v[31] ? 10'h001 : 10'h080;
        if (v[30:0] == 31'd0)        return v[31] ? 10'h008 : 10'h010;
        if (v[30:23] == 8'h00)       return v[31] ? 10'h004 : 10'h020;
        return v[31] ? 10'h002 : 10'h040;
    endfunction

    // Monotonic unsigned key for non-NaN binary32 values (-0 sorts below +0).
    function automatic logic [31:0] m_key(input logic [31:0] v);
        return v[31] ? ~v : (v ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] m_minmax(input logic [31:0] a, input logic [31:0] b, input bit is_max);
        if (m_isnan(a) && m_isnan(b)) return 32'h7FC0_0000;
        if (m_isnan(a)) return b;
        if (m_isnan(b)) return a;
        if (m_key(a) < m_key(b)) return is_max ? b : a;
        return is_max ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_rf();
        int idx;
        idx = 0;
        for (int i = NR - 1; i >= 0; i--)
            if (registerFile[i] !== mrf[i]) idx = i;
        total++;
        assert (registerFile === mrf)
        else begin
            bad++;
            $error("FAIL regfile f%0d observed=%h expected=%h", idx, registerFile[idx], mrf[idx]);
        end
    endtask

    task automatic check_outputs(input bit exp_valid);
        check("toXReg_valid", {31'b0, toXReg_valid}, {31'b0, exp_valid});
        check("data_toXReg", data_toXReg, mdata);
        check("illegal_instr", {31'b0, illegal_instr}, {31'b0, mill});
        check("fflags", {27'b0, fflags}, {27'b0, mflags});
        check_rf();
    endtask

    task automatic step(input bit en, input int k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] xd);
        bit          popped_x;
        logic [31:0] a, b;
        sb_t         e;
        popped_x      = 1'b0;
        enable        = en;
        instruction   = enc(k, rd, rs1, rs2);
        data_fromXReg = xd;
        @(posedge ck);
        #1;
        if (en) begin
            acc++;
            if (sb.size() > 0 && sb[0].due == acc) begin
                e = sb.pop_front();
                if (e.is_x) begin
                    mdata    = e.val;
                    popped_x = 1'b1;
                end else if (int'(e.rd) < NR) begin
                    mrf[e.rd] = e.val;
                end
                if (e.nv) mflags[4] = 1'b1;
            end
            if (k <= K_FMVWX) begin
                a       = mrf[rs1];
                b       = mrf[rs2];
                e.due   = acc + P + 1;
                e.rd    = rd;
                e.is_x  = 1'b0;
                e.nv    = 1'b0;
                e.val   = '0;
                case (k)
                    K_FSGNJ:  e.val = {b[31], a[30:0]};
                    K_FSGNJN: e.val = {~b[31], a[30:0]};
                    K_FSGNJX: e.val = {a[31] ^ b[31], a[30:0]};
                    K_FMIN:   begin e.val = m_minmax(a, b, 1'b0); e.nv = m_issnan(a) || m_issnan(b); end
                    K_FMAX:   begin e.val = m_minmax(a, b, 1'b1); e.nv = m_issnan(a) || m_issnan(b); end
                    K_FMVXW:  begin e.val = a; e.is_x = 1'b1; end
                    K_FCLASS: begin e.val = {22'b0, m_class(a)}; e.is_x = 1'b1; end
                    default:  e.val = xd;
                endcase
                sb.push_back(e);
                mill = 1'b0;
            end else begin
                mill = 1'b1;
            end
        end
        check_outputs(popped_x);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, K_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic do_reset(input bit en);
        rst         = 1'b1;
        enable      = en;
        instruction = enc(K_NOP, 5'd0, 5'd0, 5'd0);
        @(posedge ck);
        #1;
        rst = 1'b0;
        sb.delete();
        mrf    = '0;
        mdata  = '0;
        mflags = '0;
        mill   = 1'b0;
        check_outputs(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [8];
        int          k;
        bit          en;

        vals[0] = 32'h7F80_0001; vals[1] = 32'h7FC0_0000; vals[2] = 32'h8000_0000;
        vals[3] = 32'h0000_0000; vals[4] = 32'h3F80_0000; vals[5] = 32'hBF80_0000;
        vals[6] = 32'h0000_0001; vals[7] = 32'hFF80_0000;

        rst = 1'b1; enable = 1'b0; instruction = '0; data_fromXReg = '0;
        do_reset(1'b0);

        // register loads, first accepted on the edge right after reset
        step(1'b1, K_FMVWX, 5'd1,  5'd0, 5'd0, 32'h3F80_0000);
        step(1'b1, K_FMVWX, 5'd2,  5'd0, 5'd0, 32'hC000_0000);
        step(1'b1, K_FMVWX, 5'd5,  5'd0, 5'd0, 32'h7F80_0001);
        step(1'b1, K_FMVWX, 5'd6,  5'd0, 5'd0, 32'h4040_0000);
        step(1'b1, K_FMVWX, 5'd8,  5'd0, 5'd0, 32'hFF80_0000);
        step(1'b1, K_FMVWX, 5'd9,  5'd0, 5'd0, 32'h7FC0_0000);
        step(1'b1, K_FMVWX, 5'd10, 5'd0, 5'd0, 32'h8000_0000);
        step(1'b1, K_FMVWX, 5'd11, 5'd0, 5'd0, 32'h0000_0000);
        drain(P + 1);

        // sign injection, signed zeros, sNaN min/max
        step(1'b1, K_FSGNJN, 5'd3,  5'd1,  5'd2,  32'd0);
        step(1'b1, K_FMIN,   5'd4,  5'd10, 5'd11, 32'd0);
        step(1'b1, K_FMAX,   5'd12, 5'd10, 5'd11, 32'd0);
        step(1'b1, K_FMAX,   5'd7,  5'd5,  5'd6,  32'd0);
        drain(P + 1);
        check("f3_fsgnjn", registerFile[3], 32'h3F80_0000);
        check("f4_fmin_zero", registerFile[4], 32'h8000_0000);
        check("f12_fmax_zero", registerFile[12], 32'h0000_0000);
        check("f7_fmax_snan", registerFile[7], 32'h4040_0000);
        check("fflags_nv", {27'b0, fflags}, 32'h0000_0010);

        // FCLASS results on consecutive retire edges
        step(1'b1, K_FCLASS, 5'd1, 5'd8, 5'd0, 32'd0);
        step(1'b1, K_FCLASS, 5'd1, 5'd9, 5'd0, 32'd0);
        drain(P);
        check("fclass_neginf", data_toXReg, 32'h0000_0001);
        check("fclass_neginf_valid", {31'b0, toXReg_valid}, 32'd1);
        drain(1);
        check("fclass_qnan", data_toXReg, 32'h0000_0200);
        drain(1);
        check("fclass_valid_drop", {31'b0, toXReg_valid}, 32'd0);

        // same-edge bypass, then no forwarding from in-flight stages
        step(1'b1, K_FMVWX, 5'd13, 5'd0, 5'd0, 32'h1234_5678);
        drain(P);
        step(1'b1, K_FSGNJ, 5'd14, 5'd13, 5'd13, 32'd0);
        step(1'b1, K_FMVWX, 5'd15, 5'd0, 5'd0, 32'hAAAA_5555);
        step(1'b1, K_FSGNJ, 5'd16, 5'd15, 5'd15, 32'd0);
        step(1'b1, K_FADD,  5'd18, 5'd1, 5'd2, 32'd0);
        drain(P + 1);
        check("f14_bypass", registerFile[14], 32'h1234_5678);
        check("f16_no_fwd", registerFile[16], 32'h0000_0000);

        // enable held low mid-flight
        step(1'b1, K_FMVWX, 5'd17, 5'd0, 5'd0, 32'hDEAD_BEEF);
        drain(1);
        for (int i = 0; i < 3; i++) step(1'b0, K_FMVXW, 5'd0, 5'd17, 5'd0, 32'd0);
        drain(P - 1);
        check("f17_not_yet", registerFile[17], 32'h0000_0000);
        drain(1);
        check("f17_stalled_write", registerFile[17], 32'hDEAD_BEEF);

        // reset with two ops in flight
        step(1'b1, K_FMVWX, 5'd20, 5'd0, 5'd0, 32'h1111_1111);
        step(1'b1, K_FMVXW, 5'd0,  5'd17, 5'd0, 32'd0);
        do_reset(1'b1);
        drain(P + 2);
        check("rf_after_reset", {31'b0, registerFile == '0}, 32'd1);

        // mixed traffic with stalls and special values
        for (int i = 0; i < 8; i++)
            step(1'b1, K_FMVWX, 5'(i + 1), 5'd0, 5'd0, vals[i]);
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            en = ($urandom_range(0, 4) != 0);
            step(en, k, 5'($urandom_range(1, 12)), 5'($urandom_range(1, 12)),
                 5'($urandom_range(1, 12)), vals[$urandom_range(0, 7)]);
        end
        drain(P + 2);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
